cordic_vectoring_rtl: RTL and testbench

CORDIC_VECTORING_RTL -- requirements
Module: cordic_vectoring_rtl

---
 rtl/cordic_pkg.sv | 19 +
 rtl/cordic_atan_rom.sv | 21 ++
 rtl/cordic_vectoring_rtl.sv | 166 ++++++++++++++++
 tb/tb_cordic_vectoring_rtl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, arctangent table and FSM state type for the CORDIC vectoring block.
// All angles are Q3.10 radians and all coordinates are Q3.10 values.
package cordic_pkg;

  localparam int W       = 14;
  localparam int FRAC    = 10;
  localparam int ITER    = 12;
  localparam int K_INV   = 622;   // 1/K of the 12-stage CORDIC gain, in Q0.10
  localparam int PI_HALF = 1608;

  localparam int ATAN_TABLE [ITER] = '{804, 475, 251, 127, 64, 32, 16, 8, 4, 2, 1, 0};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_SCALE = 2'd2
  } state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: maps micro-rotation index i to atan(2^-i) in Q3.10.
// Indices past the end of the table return zero.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int ZW = W,
  parameter int IW = 4
) (
  input  logic [IW-1:0]        i_idx,
  output logic signed [ZW-1:0] o_atan
);

  always_comb begin
    // NOTE: assign every combinational output a default first so no path can infer a latch.
    o_atan = '0;
    for (int k = 0; k < ITER; k++) begin
      if (i_idx == IW'(k)) o_atan = ZW'(ATAN_TABLE[k]);
    end
  end

endmodule

// File: rtl/cordic_vectoring_rtl.sv
// Iterative CORDIC in vectoring mode: converts a Q3.10 point to magnitude, angle and quadrant.
// One point is processed at a time: capture with pre-rotation, ITER micro-rotations, one scaling step.
module cordic_vectoring_rtl #(
  parameter int W    = cordic_pkg::W,
  parameter int ITER = cordic_pkg::ITER
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ce,
  input  logic                valid_in,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  output logic                ready_out,
  output logic                valid_out,
  output logic [W:0]          magnitude,
  output logic signed [W-1:0] angle,
  output logic [1:0]          quarter
);

  import cordic_pkg::FRAC;
  import cordic_pkg::K_INV;
  import cordic_pkg::PI_HALF;
  import cordic_pkg::state_t;
  import cordic_pkg::S_IDLE;
  import cordic_pkg::S_ITER;
  import cordic_pkg::S_SCALE;

  // Four guard bits cover the sqrt(2) input growth and the ~1.65 CORDIC gain.
  localparam int DW = W + 4;
  localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int MW = DW + 12;
  localparam logic signed [MW-1:0] K_S       = MW'(K_INV);
  localparam logic signed [MW-1:0] RND       = MW'(1 << (FRAC - 1));
  localparam logic signed [MW-1:0] MAG_MAX   = MW'((1 << (W + 1)) - 1);
  localparam logic signed [W-1:0]  Z_PI_HALF = W'(PI_HALF);

  state_t               r_state, w_state_next;
  logic signed [DW-1:0] r_x, r_y, w_x0, w_y0, w_x_sh, w_y_sh;
  logic signed [W-1:0]  r_z, w_z0, w_atan;
  logic [IW-1:0]        r_i;
  logic [1:0]           r_quad, w_quad;
  logic                 r_zero;
  logic                 w_accept, w_last;
  logic signed [MW-1:0] w_prod, w_scaled;
  logic [W:0]           w_mag;
  logic                 r_valid;
  logic [W:0]           r_mag;
  logic signed [W-1:0]  r_angle;
  logic [1:0]           r_quarter;

  assign ready_out = (r_state == S_IDLE);
  assign w_accept  = ce & valid_in & ready_out;
  assign w_last    = (r_i == IW'(ITER - 1));

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (ce) begin
      case (r_state)
        S_IDLE:  if (valid_in) w_state_next = S_ITER;
        S_ITER:  if (w_last)   w_state_next = S_SCALE;
        S_SCALE: w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Left half-plane points are turned by +/-pi/2 so the micro-rotations stay in their convergence range.
  always_comb begin
    w_x0   = DW'(x_in);
    w_y0   = DW'(y_in);
    w_z0   = '0;
    w_quad = 2'd0;
    if (x_in[W-1]) begin
      if (y_in[W-1]) begin
        w_x0   = -DW'(y_in);
        w_y0   = DW'(x_in);
        w_z0   = -Z_PI_HALF;
        w_quad = 2'd2;
      end else begin
        w_x0   = DW'(y_in);
        w_y0   = -DW'(x_in);
        w_z0   = Z_PI_HALF;
        w_quad = 2'd1;
      end
    end else if (y_in[W-1]) begin
      w_quad = 2'd3;
    end
  end

  assign w_x_sh = r_x >>> r_i;
  assign w_y_sh = r_y >>> r_i;

  cordic_atan_rom #(.ZW(W), .IW(IW)) u_atan_rom (
    .i_idx  (r_i),
    .o_atan (w_atan)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_i    <= '0;
      r_quad <= '0;
      r_zero <= 1'b0;
    end else if (ce) begin
      if (w_accept) begin
        r_x    <= w_x0;
        r_y    <= w_y0;
        r_z    <= w_z0;
        r_i    <= '0;
        r_quad <= w_quad;
        r_zero <= (x_in == '0) && (y_in == '0);
      end else if (r_state == S_ITER) begin
        if (!r_y[DW-1]) begin
          r_x <= r_x + w_y_sh;
          r_y <= r_y - w_x_sh;
          r_z <= r_z + w_atan;
        end else begin
          r_x <= r_x - w_y_sh;
          r_y <= r_y + w_x_sh;
          r_z <= r_z - w_atan;
        end
        r_i <= r_i + 1'b1;
      end
    end
  end

  // Gain compensation with round-half-up, clamped to the unsigned output range.
  assign w_prod   = MW'(r_x) * K_S;
  assign w_scaled = (w_prod + RND) >>> FRAC;

  always_comb begin
    w_mag = '0;
    if (w_scaled > MAG_MAX)    w_mag = '1;
    else if (!w_scaled[MW-1]) w_mag = w_scaled[W:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid   <= 1'b0;
      r_mag     <= '0;
      r_angle   <= '0;
      r_quarter <= '0;
    end else if (ce) begin
      r_valid <= (r_state == S_SCALE);
      if (r_state == S_SCALE) begin
        r_mag     <= w_mag;
        r_angle   <= r_zero ? '0 : r_z;   // the origin has no direction; report 0
        r_quarter <= r_quad;
      end
    end
  end

  assign valid_out = r_valid;
  assign magnitude = r_mag;
  assign angle     = r_angle;
  assign quarter   = r_quarter;

endmodule

// File: tb/tb_cordic_vectoring_rtl.sv
// Self-checking bench for cordic_vectoring_rtl: directed vector table, back-to-back, clock-enable,
// mid-run reset and an ellipse sweep, all against hand-derived or bench-computed expectations.
module tb_cordic_vectoring_rtl;

  localparam int ITER_N  = 12;
  localparam int LAT     = ITER_N + 1;
  localparam int TWO_PI  = 6434;
  localparam real PI_R   = 3.14159265358979;

  logic               clock = 1'b0;
  logic               reset;
  logic               ce;
  logic               valid_in;
  logic signed [13:0] x_in;
  logic signed [13:0] y_in;
  logic               ready_out;
  logic               valid_out;
  logic [14:0]        magnitude;
  logic signed [13:0] angle;
  logic [1:0]         quarter;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string name;
    int    x;
    int    y;
    int    mag;
    int    mag_tol;
    int    ang;
    int    ang_tol;
    int    quad;
  } vec_t;

  vec_t vecs [9];

  cordic_vectoring_rtl #(.W(14), .ITER(ITER_N)) dut (
    .clock     (clock),
    .reset     (reset),
    .ce        (ce),
    .valid_in  (valid_in),
    .x_in      (x_in),
    .y_in      (y_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .magnitude (magnitude),
    .angle     (angle),
    .quarter   (quarter)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int actual, input int lo, input int hi);
    n_checks++;
    if (actual < lo || actual > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, actual, lo, hi);
    end
  endtask

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic int quad_of(input int x, input int y);
    if (x < 0) return (y < 0) ? 2 : 1;
    return (y < 0) ? 3 : 0;
  endfunction

  // Presents one point, then waits (bounded) for valid_out. Returns sampled outputs and edge counts.
  task automatic run_point(input int px, input int py, input bit toggle_ce,
                           output int mag, output int ang, output int q,
                           output int edges, output int lows, output bit got);
    logic signed [13:0] tx, ty;
    tx = px[13:0];
    ty = py[13:0];
    @(negedge clock);
    ce = 1'b1;
    x_in = tx;
    y_in = ty;
    valid_in = 1'b1;
    @(posedge clock);
    @(negedge clock);
    valid_in = 1'b0;
    edges = 0;
    lows  = 0;
    got   = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      if (toggle_ce) ce = (c % 2 == 1);
      @(posedge clock);
      edges++;
      if (!ce) lows++;
      #1;
      if (valid_out) got = 1'b1;
      else @(negedge clock);
    end
    mag = int'(magnitude);
    ang = int'(angle);
    q   = int'(quarter);
  endtask

  initial begin
    int mag, ang, q, edges, lows, pulses, prev_ang, d, ex, ey, ea;
    bit got;
    real t;

    vecs[0] = '{"p1024_0",     1024,    0,  1024, 3,     0, 2, 0};
    vecs[1] = '{"p0_1024",        0, 1024,  1024, 3,  1608, 2, 0};
    vecs[2] = '{"p724_m724",    724, -724,  1024, 3,  -804, 2, 3};
    vecs[3] = '{"pm1024_0",   -1024,    0,  1024, 3,  3216, 2, 1};
    vecs[4] = '{"origin",         0,    0,     0, 0,     0, 0, 0};
    vecs[5] = '{"p8191_8191",  8191, 8191, 11585, 4,   804, 2, 0};
    vecs[6] = '{"p0_m1024",       0,-1024,  1024, 3, -1608, 2, 3};
    vecs[7] = '{"pm724_m724",  -724, -724,  1024, 4, -2413, 3, 2};
    vecs[8] = '{"pm512_887",   -512,  887,  1024, 4,  2145, 3, 1};

    reset = 1'b0;
    ce = 1'b1;
    valid_in = 1'b0;
    x_in = '0;
    y_in = '0;
    #12;
    check("reset_ready", int'(ready_out), 1, 1);
    check("reset_valid", int'(valid_out), 0, 0);
    check("reset_mag",   int'(magnitude), 0, 0);
    check("reset_angle", int'(angle), 0, 0);
    check("reset_quarter", int'(quarter), 0, 0);
    @(negedge clock);
    reset = 1'b1;

    // Directed table
    for (int k = 0; k < 9; k++) begin
      run_point(vecs[k].x, vecs[k].y, 1'b0, mag, ang, q, edges, lows, got);
      check({vecs[k].name, "_valid"}, int'(got), 1, 1);
      check({vecs[k].name, "_latency"}, edges, LAT, LAT);
      check({vecs[k].name, "_mag"}, mag, vecs[k].mag - vecs[k].mag_tol, vecs[k].mag + vecs[k].mag_tol);
      check({vecs[k].name, "_angle"}, ang, vecs[k].ang - vecs[k].ang_tol, vecs[k].ang + vecs[k].ang_tol);
      check({vecs[k].name, "_quarter"}, q, vecs[k].quad, vecs[k].quad);
    end

    // Back-to-back: second point held on valid_in while busy is ignored until the valid_out cycle.
    @(negedge clock);
    x_in = 14'sd0;
    y_in = 14'sd1024;
    valid_in = 1'b1;
    @(posedge clock);
    #1;
    check("busy_ready_low", int'(ready_out), 0, 0);
    @(negedge clock);
    x_in = -14'sd1024;
    y_in = 14'sd0;
    pulses = 0;
    for (int e = 1; e <= 32; e++) begin
      @(posedge clock);
      #1;
      if (valid_out) begin
        pulses++;
        if (pulses == 1) begin
          check("b2b_first_edge", e, LAT, LAT);
          check("b2b_first_ready", int'(ready_out), 1, 1);
          check("b2b_first_angle", int'(angle), 1606, 1610);
        end else if (pulses == 2) begin
          check("b2b_second_edge", e, 2 * LAT + 1, 2 * LAT + 1);
          check("b2b_second_angle", int'(angle), 3214, 3218);
          check("b2b_second_quarter", int'(quarter), 1, 1);
        end
      end
      @(negedge clock);
      if (e == LAT + 1) valid_in = 1'b0;
    end
    check("b2b_pulse_count", pulses, 2, 2);

    // Clock enable toggled every cycle during a computation
    run_point(8191, 8191, 1'b1, mag, ang, q, edges, lows, got);
    check("ce_valid", int'(got), 1, 1);
    check("ce_low_cycles_seen", lows, 1, 1000);
    check("ce_latency_stretch", edges - lows, LAT, LAT);
    check("ce_mag", mag, 11581, 11589);
    check("ce_angle", ang, 802, 806);
    @(negedge clock);
    ce = 1'b0;
    @(posedge clock);
    #1;
    check("ce_valid_hold", int'(valid_out), 1, 1);
    @(negedge clock);
    ce = 1'b1;
    @(posedge clock);
    #1;
    check("ce_valid_drop", int'(valid_out), 0, 0);
    check("ce_mag_hold", int'(magnitude), 11581, 11589);

    // Reset at cycle 5 of a computation
    @(negedge clock);
    x_in = 14'sd1024;
    y_in = 14'sd0;
    valid_in = 1'b1;
    @(posedge clock);
    @(negedge clock);
    valid_in = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_ready", int'(ready_out), 1, 1);
    check("midrst_mag", int'(magnitude), 0, 0);
    check("midrst_angle", int'(angle), 0, 0);
    check("midrst_quarter", int'(quarter), 0, 0);
    @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clock);
      #1;
      if (valid_out) pulses++;
    end
    check("midrst_no_valid", pulses, 0, 0);
    run_point(0, -1024, 1'b0, mag, ang, q, edges, lows, got);
    check("postrst_valid", int'(got), 1, 1);
    check("postrst_latency", edges, LAT, LAT);
    check("postrst_angle", ang, -1610, -1606);
    check("postrst_quarter", q, 3, 3);

    // Ellipse sweep, semi-axes 4000 x 2000 in Q3.10
    prev_ang = 0;
    for (int k = 0; k < 32; k++) begin
      t  = 2.0 * PI_R * (real'(k) + 0.3) / 32.0;
      ex = rnd(4000.0 * $cos(t));
      ey = rnd(2000.0 * $sin(t));
      ea = rnd($atan2(real'(ey), real'(ex)) * 1024.0);
      run_point(ex, ey, 1'b0, mag, ang, q, edges, lows, got);
      check("ellipse_valid", int'(got), 1, 1);
      check("ellipse_quarter", q, quad_of(ex, ey), quad_of(ex, ey));
      d = ang - ea;
      if (d > TWO_PI / 2)  d -= TWO_PI;
      if (d < -TWO_PI / 2) d += TWO_PI;
      check("ellipse_angle_err", d, -3, 3);
      if (k > 0) begin
        d = ang - prev_ang;
        if (d < 0) d += TWO_PI;
        check("ellipse_monotonic_step", d, 1, TWO_PI / 2);
      end
      prev_ang = ang;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
